// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder: recovers BCD digits, sign and binary magnitude from a
// digit-multiplexed 7-segment stream (low, high, sign). A value is reported
// once it has been seen in STABLE_CNT identical consecutive frames.
module seg_frame_decoder #(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg_in,
  input  logic [1:0] dig_sel,
  input  logic       seg_vld,
  output logic [3:0] digit_l,
  output logic [3:0] digit_h,
  output logic [6:0] value,
  output logic       sign,
  output logic       val_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    WAIT_L = 2'd0,
    WAIT_H = 2'd1,
    WAIT_S = 2'd2,
    CONV   = 2'd3
  } state_t;

  localparam logic [3:0] STABLE_TH = 4'(STABLE_CNT);

  // Returns {legal, digit} for a numeric segment pattern (dp stripped).
  function automatic logic [4:0] decode_digit(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'b1111110: r = {1'b1, 4'd0};
      7'b0110000: r = {1'b1, 4'd1};
      7'b1101101: r = {1'b1, 4'd2};
      7'b1111001: r = {1'b1, 4'd3};
      7'b0110011: r = {1'b1, 4'd4};
      7'b1011011: r = {1'b1, 4'd5};
      7'b1011111: r = {1'b1, 4'd6};
      7'b1110000: r = {1'b1, 4'd7};
      7'b1111111: r = {1'b1, 4'd8};
      7'b1111011: r = {1'b1, 4'd9};
      default:    r = 5'd0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  lo_q, lo_d;          // partial frame: low digit
  logic [3:0]  hi_q, hi_d;          // partial frame: high digit
  logic        neg_q, neg_d;        // partial frame: sign
  logic [8:0]  last_q, last_d;      // last complete frame {sign, h, l}
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic        reported_q, reported_d;
  logic [3:0]  digit_l_q, digit_l_d;
  logic [3:0]  digit_h_q, digit_h_d;
  logic [6:0]  value_q, value_d;
  logic        sign_q, sign_d;
  logic        val_valid_q, val_valid_d;
  logic        err_q, err_d;

  logic [6:0]  pat;
  logic        l_ok, h_ok, s_ok, s_neg, blank, pat_ok, low_ok;
  logic [3:0]  l_dig;
  logic [1:0]  exp_sel;
  logic        strobe, good, relow, bad, illegal;
  logic [6:0]  mag;
  logic [8:0]  frame;

  // Classify the incoming strobe against the digit expected in this state.
  always_comb begin
    pat            = seg_in[7:1];
    {l_ok, l_dig}  = decode_digit(pat);
    blank          = (pat == 7'b0000000);
    h_ok           = l_ok | blank;
    s_neg          = (pat == 7'b0000001);
    s_ok           = s_neg | blank;
    case (dig_sel)
      2'd0:    pat_ok = l_ok;
      2'd1:    pat_ok = h_ok;
      2'd2:    pat_ok = s_ok;
      default: pat_ok = 1'b1;       // reserved select is an order fault, not a pattern fault
    endcase
    case (state_q)
      WAIT_H:  exp_sel = 2'd1;
      WAIT_S:  exp_sel = 2'd2;
      default: exp_sel = 2'd0;
    endcase
    low_ok  = (dig_sel == 2'd0) && l_ok;
    strobe  = seg_vld && (state_q != CONV);
    good    = strobe && pat_ok && (dig_sel == exp_sel);
    // A repeated low digit while waiting for the high digit simply replaces it.
    relow   = strobe && (state_q == WAIT_H) && low_ok;
    bad     = strobe && !good && !relow;
    illegal = strobe && (dig_sel != 2'd3) && !pat_ok;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CONV: state_d = WAIT_L;
      default: begin
        if (good) begin
          case (state_q)
            WAIT_L:  state_d = WAIT_H;
            WAIT_H:  state_d = WAIT_S;
            default: state_d = CONV;
          endcase
        end else if (relow || bad) begin
          state_d = low_ok ? WAIT_H : WAIT_L;
        end
      end
    endcase
  end

  // Datapath: capture digits, track frame stability, produce reports and errors.
  always_comb begin
    lo_d        = lo_q;
    hi_d        = hi_q;
    neg_d       = neg_q;
    last_d      = last_q;
    match_cnt_d = match_cnt_q;
    reported_d  = reported_q;
    digit_l_d   = digit_l_q;
    digit_h_d   = digit_h_q;
    value_d     = value_q;
    sign_d      = sign_q;
    val_valid_d = 1'b0;
    err_d       = bad;
    mag         = {hi_q, 3'b000} + {2'b00, hi_q, 1'b0} + {3'b000, lo_q};
    frame       = {neg_q, hi_q, lo_q};

    if (strobe && low_ok) lo_d = l_dig;
    if (good && (state_q == WAIT_H)) hi_d = l_dig;   // blank decodes to 0
    if (good && (state_q == WAIT_S)) neg_d = s_neg;
    if (illegal) match_cnt_d = 4'd0;

    if (state_q == CONV) begin
      if ((mag == 7'd0) && neg_q) begin
        err_d       = 1'b1;
        match_cnt_d = 4'd0;
      end else begin
        if (frame == last_q) begin
          match_cnt_d = (match_cnt_q == 4'd15) ? 4'd15 : match_cnt_q + 4'd1;
        end else begin
          last_d      = frame;
          match_cnt_d = 4'd1;
          reported_d  = 1'b0;
        end
        if ((match_cnt_d >= STABLE_TH) && !reported_d) begin
          digit_l_d   = lo_q;
          digit_h_d   = hi_q;
          value_d     = mag;
          sign_d      = neg_q;
          val_valid_d = 1'b1;
          reported_d  = 1'b1;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_L;
      lo_q        <= 4'd0;
      hi_q        <= 4'd0;
      neg_q       <= 1'b0;
      last_q      <= 9'd0;
      match_cnt_q <= 4'd0;
      reported_q  <= 1'b0;
      digit_l_q   <= 4'd0;
      digit_h_q   <= 4'd0;
      value_q     <= 7'd0;
      sign_q      <= 1'b0;
      val_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      neg_q       <= neg_d;
      last_q      <= last_d;
      match_cnt_q <= match_cnt_d;
      reported_q  <= reported_d;
      digit_l_q   <= digit_l_d;
      digit_h_q   <= digit_h_d;
      value_q     <= value_d;
      sign_q      <= sign_d;
      val_valid_q <= val_valid_d;
      err_q       <= err_d;
    end
  end

  assign digit_l   = digit_l_q;
  assign digit_h   = digit_h_q;
  assign value     = value_q;
  assign sign      = sign_q;
  assign val_valid = val_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: two instances (STABLE_CNT=3 and 1) share one
// stimulus stream; a frame-level reference model predicts reports and errors.
module tb_seg_frame_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic [1:0] dig_sel;
  logic       seg_vld;

  logic [3:0] a_dl, a_dh, b_dl, b_dh;
  logic [6:0] a_val, b_val;
  logic       a_sign, a_vv, a_err, b_sign, b_vv, b_err;

  seg_frame_decoder #(.STABLE_CNT(3)) u_a (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel), .seg_vld(seg_vld),
    .digit_l(a_dl), .digit_h(a_dh), .value(a_val), .sign(a_sign),
    .val_valid(a_vv), .err(a_err)
  );

  seg_frame_decoder #(.STABLE_CNT(1)) u_b (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel), .seg_vld(seg_vld),
    .digit_l(b_dl), .digit_h(b_dh), .value(b_val), .sign(b_sign),
    .val_valid(b_vv), .err(b_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10];
  localparam logic [6:0] BLANK = 7'b0000000;
  localparam logic [6:0] MINUS = 7'b0000001;

  // Reference model: partial frame collected so far, and per-instance history.
  int m_have, m_l, m_h, m_s;
  int thr    [2];
  int m_cnt  [2];
  int m_rep  [2];
  int m_last [2];   // frame identity: sign*100 + magnitude
  int m_ol   [2];
  int m_oh   [2];
  int m_os   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, " a.digit_l"}, 32'(a_dl),   32'(m_ol[0]));
    chk({tag, " a.digit_h"}, 32'(a_dh),   32'(m_oh[0]));
    chk({tag, " a.value"},   32'(a_val),  32'(m_oh[0] * 10 + m_ol[0]));
    chk({tag, " a.sign"},    32'(a_sign), 32'(m_os[0]));
    chk({tag, " b.digit_l"}, 32'(b_dl),   32'(m_ol[1]));
    chk({tag, " b.digit_h"}, 32'(b_dh),   32'(m_oh[1]));
    chk({tag, " b.value"},   32'(b_val),  32'(m_oh[1] * 10 + m_ol[1]));
    chk({tag, " b.sign"},    32'(b_sign), 32'(m_os[1]));
  endtask

  function automatic int dec_digit(input logic [6:0] p);
    for (int k = 0; k < 10; k++) if (seg_tab[k] == p) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_have = 0; m_l = 0; m_h = 0; m_s = 0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rep[i] = 0; m_last[i] = 0;
      m_ol[i] = 0; m_oh[i] = 0; m_os[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; seg_vld = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    $display("reset applied");
    chk("reset a.val_valid", 32'(a_vv), 0);
    chk("reset a.err", 32'(a_err), 0);
    chk("reset b.val_valid", 32'(b_vv), 0);
    chk("reset b.err", 32'(b_err), 0);
    chk_outs("reset");
  endtask

  // One strobe: predict the effect, drive it for a cycle, check err and, if the
  // frame completed, the report two cycles after the strobe.
  task automatic strobe(input logic [1:0] sel, input logic [6:0] pat, input string tag);
    int lv, hv, sv, mag, fid;
    bit legal, e, done, nz;
    bit [1:0] vv;
    lv = dec_digit(pat);
    hv = (lv >= 0) ? lv : ((pat == BLANK) ? 0 : -1);
    sv = (pat == MINUS) ? 1 : ((pat == BLANK) ? 0 : -1);
    case (sel)
      2'd0: legal = (lv >= 0);
      2'd1: legal = (hv >= 0);
      2'd2: legal = (sv >= 0);
      default: legal = 1'b1;
    endcase
    e = 0; done = 0; nz = 0; vv = 2'b00;
    if (int'(sel) == m_have && legal) begin
      if (sel == 2'd0) m_l = lv;
      else if (sel == 2'd1) m_h = hv;
      else m_s = sv;
      m_have++;
      if (m_have == 3) begin done = 1; m_have = 0; end
    end else if (m_have == 1 && sel == 2'd0 && legal) begin
      m_l = lv;
    end else begin
      e = 1;
      if (sel != 2'd3 && !legal) for (int i = 0; i < 2; i++) m_cnt[i] = 0;
      if (sel == 2'd0 && legal) begin m_l = lv; m_have = 1; end
      else m_have = 0;
    end

    @(negedge clk);
    seg_in = {pat, 1'($urandom)}; dig_sel = sel; seg_vld = 1'b1;
    @(negedge clk);
    seg_vld = 1'b0; seg_in = 8'($urandom); dig_sel = 2'($urandom);
    $display("strobe %s sel=%0d pat=%07b exp_err=%0d done=%0d", tag, sel, pat, e, done);
    chk({tag, " a.err"}, 32'(a_err), 32'(e));
    chk({tag, " b.err"}, 32'(b_err), 32'(e));
    chk({tag, " a.val_valid early"}, 32'(a_vv), 0);
    chk({tag, " b.val_valid early"}, 32'(b_vv), 0);
    if (!done) begin
      chk_outs(tag);
    end else begin
      mag = m_h * 10 + m_l;
      for (int i = 0; i < 2; i++) begin
        if (mag == 0 && m_s == 1) begin
          nz = 1; m_cnt[i] = 0;
        end else begin
          fid = m_s * 100 + mag;
          if (fid == m_last[i]) m_cnt[i] = (m_cnt[i] >= 15) ? 15 : m_cnt[i] + 1;
          else begin m_last[i] = fid; m_cnt[i] = 1; m_rep[i] = 0; end
          if (m_cnt[i] >= thr[i] && m_rep[i] == 0) begin
            vv[i] = 1'b1; m_rep[i] = 1;
            m_ol[i] = m_l; m_oh[i] = m_h; m_os[i] = m_s;
          end
        end
      end
      @(negedge clk);
      $display("frame %s value=%0d sign=%0d exp_vv=%0d%0d exp_err=%0d", tag, mag, m_s, vv[0], vv[1], nz);
      chk({tag, " a.val_valid"}, 32'(a_vv), 32'(vv[0]));
      chk({tag, " b.val_valid"}, 32'(b_vv), 32'(vv[1]));
      chk({tag, " a.err conv"}, 32'(a_err), 32'(nz));
      chk({tag, " b.err conv"}, 32'(b_err), 32'(nz));
      chk_outs(tag);
    end
  endtask

  task automatic frame(input logic [6:0] pl, input logic [6:0] ph, input logic [6:0] ps,
                       input string tag);
    strobe(2'd0, pl, tag);
    strobe(2'd1, ph, tag);
    strobe(2'd2, ps, tag);
  endtask

  initial begin
    int v, n;
    logic [6:0] ps, ph;
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
    seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1111011;
    thr[0] = 3; thr[1] = 1;
    reset = 1'b1; seg_in = 8'd0; dig_sel = 2'd0; seg_vld = 1'b0;
    model_reset();

    do_reset();

    // Stable 75: reported once after the third frame, not on the fourth.
    repeat (4) frame(seg_tab[5], seg_tab[7], BLANK, "f75");
    chk("f75 a.value const", 32'(a_val), 32'd75);
    chk("f75 a.digit_h const", 32'(a_dh), 32'd7);

    // -1, then 42, then -1 again (reported again after a change).
    repeat (3) frame(seg_tab[1], BLANK, MINUS, "fm1");
    chk("fm1 a.sign const", 32'(a_sign), 32'd1);
    repeat (3) frame(seg_tab[2], seg_tab[4], BLANK, "f42");
    chk("f42 a.value const", 32'(a_val), 32'd42);
    repeat (3) frame(seg_tab[1], BLANK, MINUS, "fm1b");

    // Illegal low pattern, then three frames of 9.
    strobe(2'd0, 7'b1100110, "illegal");
    repeat (3) frame(seg_tab[9], seg_tab[0], BLANK, "f9");
    chk("f9 a.value const", 32'(a_val), 32'd9);

    // Order violation L,S then a repeated low digit L,L,H,S.
    strobe(2'd0, seg_tab[5], "order_l");
    strobe(2'd2, BLANK, "order_s");
    strobe(2'd0, seg_tab[3], "relow1");
    frame(seg_tab[4], seg_tab[2], BLANK, "relow2");
    strobe(2'd3, seg_tab[1], "reserved");

    // Minus zero.
    frame(seg_tab[0], BLANK, MINUS, "mzero");

    // Reset in the middle of a stable run of 33.
    repeat (2) frame(seg_tab[3], seg_tab[3], BLANK, "f33pre");
    strobe(2'd0, seg_tab[3], "f33part");
    do_reset();
    repeat (3) frame(seg_tab[3], seg_tab[3], BLANK, "f33post");
    chk("f33 a.value const", 32'(a_val), 32'd33);

    // 10, 10, 11: two reports on the STABLE_CNT=1 instance.
    frame(seg_tab[0], seg_tab[1], BLANK, "f10a");
    frame(seg_tab[0], seg_tab[1], BLANK, "f10b");
    frame(seg_tab[1], seg_tab[1], BLANK, "f11");
    chk("f11 b.value const", 32'(b_val), 32'd11);

    // Randomized runs of frames drawn from a small pool, with occasional faults.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: v = 7;
        1: v = 58;
        2: v = 99;
        default: v = 0;
      endcase
      ps = ($urandom_range(0, 3) == 0) ? MINUS : BLANK;
      n  = $urandom_range(1, 4);
      for (int r = 0; r < n; r++) begin
        ph = (v / 10 == 0 && $urandom_range(0, 1) == 1) ? BLANK : seg_tab[v / 10];
        case ($urandom_range(0, 9))
          0: strobe(2'd0, 7'b0000001, "rnd_bad_pat");
          1: begin strobe(2'd0, seg_tab[v % 10], "rnd_skip"); strobe(2'd2, ps, "rnd_skip"); end
          2: strobe(2'd3, seg_tab[v % 10], "rnd_sel3");
          default: ;
        endcase
        frame(seg_tab[v % 10], ph, ps, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
